// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline front end.
//   INSTR_W       - instruction / address width
//   NOP_INSTR     - bubble encoding shown when no instruction is held
//   fetch_state_t - fetch FSM state encoding
package pipe_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // S_IDLE: nothing outstanding, S_WAIT: request outstanding,
  // S_DROP: outstanding request invalidated, S_HOLD: buffer valid
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: redirect priority and target selection for the fetch stage.
// Ports:
//   PCSrcW, ResultW             - Writeback redirect and its target
//   BranchTakenE, BranchTargetE - Execute redirect and its target
//   redir                       - any redirect this cycle
//   target                      - new PC when redir is high
module fetch_pc_sel
  import pipe_pkg::*;
(
  input  logic               PCSrcW,
  input  logic [INSTR_W-1:0] ResultW,
  input  logic               BranchTakenE,
  input  logic [INSTR_W-1:0] BranchTargetE,
  output logic               redir,
  output logic [INSTR_W-1:0] target
);

  // Writeback is the older instruction, so its PC write beats a branch
  // resolved in Execute when both arrive together.
  always_comb begin
    redir  = PCSrcW | BranchTakenE;
    target = PCSrcW ? ResultW : BranchTargetE;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage in front of the Fetch-to-Decode register.
// Owns the PC, keeps at most one instruction-memory read outstanding,
// buffers the returned word and presents it to Decode.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   StallF                        - Decode will not capture InstrF this cycle
//   BranchTakenE, BranchTargetE   - Execute redirect
//   PCSrcW, ResultW               - Writeback redirect (higher priority)
//   imem_req, imem_addr           - request strobe and address to imem
//   imem_rdata, imem_valid        - response word and its one-cycle strobe
//   InstrF, PCPlus4F              - held instruction (or NOP) and its PC+4
//   FetchValidF, FetchBusyF       - instruction held / bubble Decode
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               BranchTakenE,
  input  logic [INSTR_W-1:0] BranchTargetE,
  input  logic               PCSrcW,
  input  logic [INSTR_W-1:0] ResultW,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] InstrF,
  output logic [INSTR_W-1:0] PCPlus4F,
  output logic               FetchValidF,
  output logic               FetchBusyF
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] buffer;
  logic [INSTR_W-1:0] req_addr;
  logic [INSTR_W-1:0] pc_plus4;
  logic [INSTR_W-1:0] issue_addr;
  logic [INSTR_W-1:0] target;
  logic               redir;
  logic               issue;

  fetch_pc_sel u_pc_sel (
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .redir         (redir),
    .target        (target)
  );

  assign pc_plus4 = pc + 32'd4;

  // A request goes out from S_IDLE, or from S_HOLD in the very cycle Decode
  // takes the held word, so the next fetch overlaps the handoff. Any
  // redirect suppresses the request because the PC is about to change.
  always_comb begin
    issue      = 1'b0;
    issue_addr = pc;
    case (state)
      S_IDLE: issue = !redir;
      S_HOLD: begin
        issue      = !redir && !StallF;
        issue_addr = pc_plus4;
      end
      default: issue = 1'b0;
    endcase
  end

  // req_addr keeps the address on the bus for the whole life of the
  // request, even after a redirect has already moved the PC on (S_DROP).
  assign imem_req  = issue && !reset;
  assign imem_addr = issue ? issue_addr : req_addr;

  // Fetch FSM: PC, buffered word and outstanding-request tracking.
  // Redirects are checked first in every state so they always beat StallF.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      buffer   <= NOP_INSTR;
      req_addr <= RESET_PC;
    end else begin
      if (issue) begin
        req_addr <= issue_addr;
      end
      case (state)
        S_IDLE: begin
          if (redir) begin
            pc <= target;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redir) begin
            pc    <= target;
            state <= imem_valid ? S_IDLE : S_DROP;
          end else if (imem_valid) begin
            buffer <= imem_rdata;
            state  <= S_HOLD;
          end
        end
        S_DROP: begin
          if (redir) begin
            pc <= target;
          end
          if (imem_valid) begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc     <= target;
            buffer <= NOP_INSTR;
            state  <= S_IDLE;
          end else if (!StallF) begin
            pc    <= pc_plus4;
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    FetchValidF = (state == S_HOLD);
    FetchBusyF  = !FetchValidF;
    InstrF      = FetchValidF ? buffer : NOP_INSTR;
    PCPlus4F    = pc_plus4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A behavioural instruction
// memory with programmable latency answers requests; accepted responses are
// queued as expected instructions and popped when the fetch stage shows them.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        FetchValidF;
  logic        FetchBusyF;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .InstrF        (InstrF),
    .PCPlus4F      (PCPlus4F),
    .FetchValidF   (FetchValidF),
    .FetchBusyF    (FetchBusyF)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model of the fetch stage
  logic        shown = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] sb[$];

  // memory model
  int          lat = 1;
  int          mem_cnt = 0;
  bit          mem_pending = 1'b0;
  bit          mem_drop = 1'b0;
  bit          resp_drop = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] resp_addr = 32'h0;

  // observation bookkeeping
  logic        prev_fv = 1'b0;
  int          shown_count = 0;
  bit          req_seen = 1'b0;
  logic [31:0] last_req_addr = 32'h0;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at the falling edge: compare DUT against the model, capture
  // requests into the memory model, then advance the model to the next cycle.
  task automatic sampleCycle();
    logic        redir;
    logic [31:0] target;
    logic        exp_req;
    logic        accepted;
    redir  = PCSrcW | BranchTakenE;
    target = PCSrcW ? ResultW : BranchTargetE;

    if (FetchValidF && !prev_fv) begin
      shown_count++;
      if (sb.size() == 0) checkOutput("spurious_instr", 32'(FetchValidF), 32'd0);
      else exp_instr = sb.pop_front();
    end
    prev_fv = FetchValidF;

    checkOutput("valid", 32'(FetchValidF), 32'(shown));
    checkOutput("busy", 32'(FetchBusyF), 32'(!shown));
    checkOutput("instr", InstrF, shown ? exp_instr : NOP);
    checkOutput("pcplus4", PCPlus4F, exp_pc + 32'd4);

    exp_req = !reset && !redir &&
              ((shown && !StallF) || (!shown && !mem_pending && !imem_valid));
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_valid) checkOutput("addr_stable", imem_addr, resp_addr);

    if (mem_pending && redir) mem_drop = 1'b1;
    req_seen = 1'b0;
    if (imem_req) begin
      req_seen      = 1'b1;
      last_req_addr = imem_addr;
      req_log.push_back(imem_addr);
      if (exp_req) checkOutput("imem_addr", imem_addr, shown ? exp_pc + 32'd4 : exp_pc);
      mem_pending = 1'b1;
      mem_cnt     = lat;
      mem_addr    = imem_addr;
      mem_drop    = 1'b0;
    end

    accepted = imem_valid && !reset && !redir && !resp_drop;
    if (accepted) sb.push_back(mem_word(resp_addr));

    if (reset) begin
      shown       = 1'b0;
      exp_pc      = 32'h0;
      mem_pending = 1'b0;
      mem_drop    = 1'b0;
      sb.delete();
    end else if (redir) begin
      exp_pc = target;
      shown  = 1'b0;
    end else if (shown && !StallF) begin
      exp_pc = exp_pc + 32'd4;
      shown  = 1'b0;
    end else if (accepted) begin
      shown = 1'b1;
    end
  endtask

  // One clock: sample at negedge, then drive the memory response for the
  // next cycle just after the rising edge.
  task automatic step();
    @(negedge clk);
    sampleCycle();
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_valid  = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        resp_addr   = mem_addr;
        resp_drop   = mem_drop;
        mem_pending = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] brt,
                               input logic pcsrc, input logic [31:0] res);
    StallF        = stall;
    BranchTakenE  = br;
    BranchTargetE = brt;
    PCSrcW        = pcsrc;
    ResultW       = res;
    step();
    BranchTakenE  = 1'b0;
    PCSrcW        = 1'b0;
  endtask

  task automatic waitReq(input int max_cycles, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      step();
      if (req_seen) found = 1'b1;
    end
    if (!found) checkOutput({tag, "_timeout"}, 32'(req_seen), 32'd1);
  endtask

  task automatic waitShown(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && !shown; i++) step();
    if (!shown) checkOutput({tag, "_timeout"}, 32'(FetchValidF), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_valid"}, 32'(FetchValidF), 32'd0);
    checkOutput({tag, "_busy"}, 32'(FetchBusyF), 32'd1);
    checkOutput({tag, "_instr"}, InstrF, NOP);
    checkOutput({tag, "_pcplus4"}, PCPlus4F, 32'd4);
  endtask

  initial begin
    int n0;
    int ns;
    reset         = 1'b1;
    StallF        = 1'b0;
    BranchTakenE  = 1'b0;
    BranchTargetE = 32'h0;
    PCSrcW        = 1'b0;
    ResultW       = 32'h0;
    imem_valid    = 1'b0;
    imem_rdata    = 32'h0;

    step();
    step();
    checkResetOutputs("rst");
    reset = 1'b0;
    req_log.delete();

    // streaming with a 1-cycle memory
    $display("[TB] streaming, 1-cycle memory");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("t1_addr%0d", k),
                  (k < req_log.size()) ? req_log[k] : 32'hDEAD_BEEF, 32'(k * 4));

    // stall while holding the word fetched from 0xC
    $display("[TB] stall in hold");
    StallF = 1'b1;
    waitShown(5, "t2_show");
    n0 = req_log.size();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t2_instr", InstrF, mem_word(32'h0000_000C));
    checkOutput("t2_pcplus4", PCPlus4F, 32'h0000_0010);
    checkOutput("t2_noreq", 32'(req_log.size() - n0), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t2_release", last_req_addr, 32'h0000_0010);

    // branch while waiting on a slow memory
    $display("[TB] branch during wait");
    lat = 4;
    waitReq(10, "t3_req");
    checkOutput("t3_addr", last_req_addr, 32'h0000_0014);
    ns = shown_count;
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    waitReq(20, "t3_redir");
    checkOutput("t3_target", last_req_addr, 32'h0000_0100);
    checkOutput("t3_noshow", 32'(shown_count - ns), 32'd0);

    // redirect in the same cycle as the response
    $display("[TB] redirect with response");
    lat = 2;
    waitShown(20, "t4_show");
    waitReq(5, "t4_req");
    checkOutput("t4_addr", last_req_addr, 32'h0000_0104);
    step();
    ns = shown_count;
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    waitReq(10, "t4_redir");
    checkOutput("t4_target", last_req_addr, 32'h0000_0400);
    checkOutput("t4_noshow", 32'(shown_count - ns), 32'd0);

    // simultaneous redirects: Writeback wins
    $display("[TB] redirect priority");
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0200);
    waitReq(10, "t5_redir");
    checkOutput("t5_target", last_req_addr, 32'h0000_0200);

    // PC wrap at the top of the address space
    $display("[TB] pc wrap");
    lat = 1;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    waitReq(10, "t6_req");
    checkOutput("t6_addr", last_req_addr, 32'hFFFF_FFFC);
    waitShown(10, "t6_show");
    checkOutput("t6_pcplus4", PCPlus4F, 32'h0000_0000);
    checkOutput("t6_instr", InstrF, mem_word(32'hFFFF_FFFC));
    waitReq(3, "t6_wrap");
    checkOutput("t6_next", last_req_addr, 32'h0000_0000);

    // reset in the middle of a wait
    $display("[TB] reset during wait");
    lat = 4;
    waitReq(10, "t7_req");
    checkOutput("t7_addr", last_req_addr, 32'h0000_0004);
    step();
    reset = 1'b1;
    step();
    checkResetOutputs("t7_rst");
    reset = 1'b0;
    waitReq(5, "t7_restart");
    checkOutput("t7_restart_addr", last_req_addr, 32'h0000_0000);
    waitShown(10, "t7_show");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage that sits directly upstream of the Fetch-to-Decode pipeline register.
- Owns the PC register and issues one-outstanding-request reads to instruction memory.
- Buffers the returned word and presents it as InstrF, with a valid flag, for Decode to capture.
- Handles the hazard-unit stall and redirects from Execute (branch) and Writeback (PC write), including discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding driven on InstrF when no valid instruction is held.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- StallF  in  1  hazard unit: Decode will not capture InstrF this cycle.
- BranchTakenE  in  1  redirect from Execute.
- BranchTargetE  in  32  Execute redirect target.
- PCSrcW  in  1  redirect from Writeback (PC written).
- ResultW  in  32  Writeback redirect target.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  32  request address; stable from the request cycle until its response.
- imem_rdata  in  32  instruction word, valid with imem_valid.
- imem_valid  in  1  exactly one pulse per request, at least 1 cycle after imem_req.
- InstrF  out  32  fetched instruction, or NOP_INSTR.
- PCPlus4F  out  32  address of InstrF + 4.
- FetchValidF  out  1  InstrF holds a real instruction.
- FetchBusyF  out  1  no valid instruction available; hazard unit bubbles Decode.

Behaviour:
- Reset (sync, on posedge with reset=1):
  - PC=RESET_PC, state=S_IDLE, buffer=NOP_INSTR.
  - imem_req=0, FetchValidF=0, FetchBusyF=1, InstrF=NOP_INSTR.
  - A reset during an outstanding request drops that request; any later imem_valid is ignored while in S_IDLE.
- States:
  - S_IDLE: nothing outstanding.
  - S_WAIT: request outstanding.
  - S_DROP: outstanding request has been invalidated.
  - S_HOLD: buffer holds a valid instruction.
- Redirect target: redir = PCSrcW | BranchTakenE. Target is ResultW when PCSrcW=1, otherwise BranchTargetE. PCSrcW wins when both are asserted.
- Redirects override StallF in every state.
- S_IDLE:
  - If redir: PC<=target, stay S_IDLE, no request.
  - Else: imem_req=1, imem_addr=PC, go to S_WAIT.
  - Issue is independent of StallF.
- S_WAIT:
  - imem_valid & !redir: buffer<=imem_rdata, go to S_HOLD.
  - redir & imem_valid: PC<=target, go to S_IDLE; the response is discarded.
  - redir & !imem_valid: PC<=target, go to S_DROP.
- S_DROP:
  - On imem_valid: discard and go to S_IDLE.
  - A new redir in S_DROP updates PC only.
- S_HOLD:
  - redir: PC<=target, buffer discarded, go to S_IDLE.
  - StallF=1: hold PC and buffer.
  - StallF=0: Decode captures this cycle. PC<=PC+4; issue imem_req=1, imem_addr=PC+4 in the same cycle; go to S_WAIT.
- Outputs:
  - FetchValidF = (state==S_HOLD).
  - FetchBusyF = !FetchValidF.
  - InstrF = buffer in S_HOLD, else NOP_INSTR.
  - PCPlus4F = PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Latency: instruction visible on InstrF the cycle after imem_valid. Peak throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- At most one request is outstanding at any time. imem_req is never asserted in S_WAIT or S_DROP.

Decomposition:
- Shared package pipe_pkg:
  - fetch_state_t enum {S_IDLE, S_WAIT, S_DROP, S_HOLD}.
  - NOP_INSTR constant.
  - INSTR_W=32.
- Sub-module fetch_pc_sel: combinational redirect priority and target selection. Everything else stays in the top.

Test Plan:
- Reset, then 1-cycle memory, StallF=0:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - InstrF shows each word the cycle after its imem_valid.
  - FetchValidF toggles 0/1.
- S_HOLD with StallF=1 for 3 cycles:
  - InstrF and PC frozen; no imem_req.
  - On release: one request to PC+4.
- BranchTakenE=1, target 0x100, while in S_WAIT with a 4-cycle memory:
  - State goes to S_DROP; the late response is never shown.
  - Next imem_addr=0x100.
- PCSrcW=1 (ResultW=0x200) and BranchTakenE=1 (0x300) in the same cycle: next imem_addr=0x200.
- Redirect in the same cycle as imem_valid in S_WAIT:
  - Response discarded, FetchValidF stays 0.
  - Next request goes to the target.
- PC=0xFFFF_FFFC consumed: PCPlus4F=0x0 and the next imem_addr=0x0. Reset asserted mid-S_WAIT: all outputs return to their reset values next cycle.
